mdu_seq: RTL

- Multi-cycle multiply/divide unit for the RV32 core's M-extension operations.
- Sits directly downstream of the register file BR:
  - operands come from BR's rd1/rd2 read ports;
  - the result goes back to BR's a3/wd3/we write port as a one-cycle write pulse.
- Iterative, one bit per clock.
- Holds the core via busy until the write-back completes.

---
 rtl/mdu_seq_if.sv | 39 +++
 rtl/mdu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_if.sv
// ---------------------------------------------------------------------------
// mdu_seq_if - request / write-back bundle between the core, the register
// file BR and the multi-cycle multiply/divide unit.
//
// Signals:
//   start    request pulse (sampled only while the unit is idle)
//   op       funct3: 0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU
//   rs1_val  operand A (BR rd1)
//   rs2_val  operand B (BR rd2)
//   rd_addr  destination register
//   busy     unit occupied, core must stall
//   a3/wd3   write-back address/data to BR, qualified by we
//   we       one-cycle write-enable pulse to BR
//
// Modports: master = requester (core / bench), slave = mdu_seq.
// ---------------------------------------------------------------------------
interface mdu_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd_addr;
    logic            busy;
    logic [4:0]      a3;
    logic [XLEN-1:0] wd3;
    logic            we;

    modport master (
        output start, op, rs1_val, rs2_val, rd_addr,
        input  busy, a3, wd3, we
    );

    modport slave (
        input  start, op, rs1_val, rs2_val, rd_addr,
        output busy, a3, wd3, we
    );
endinterface

// File: rtl/mdu_seq.sv
// ---------------------------------------------------------------------------
// mdu_seq - iterative RV32 M-extension multiply/divide unit, one bit per clock.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (aborts any operation, no write)
//   bus    mdu_seq_if.slave: start/op/rs1_val/rs2_val/rd_addr in,
//          busy/a3/wd3/we out
//
// Flow: IDLE -> RUN (32 iterations) -> WB (one cycle) -> IDLE.
// Multiply is shift-add on magnitudes, divide is restoring shift-subtract on
// magnitudes; signs are applied after the last iteration.
//
// Build option:
//   MDU_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and
//                     multiply by zero go straight from IDLE to WB.
//                     Results are identical either way; only latency differs.
// ---------------------------------------------------------------------------
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;

`ifdef MDU_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    logic [1:0]        r_state;
    logic [2:0]        r_op;
    logic [4:0]        r_rd;
    logic [4:0]        r_cnt;
    logic [XLEN-1:0]   r_b;
    // Multiply: {high partial product, multiplier shifting out}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_res;
    logic              r_neg_rem;
    logic              r_spec;
    logic [XLEN-1:0]   r_spec_res;
    logic [4:0]        r_a3;
    logic [XLEN-1:0]   r_wd3;
    logic              r_we;

    // ---------------- operand decode (used only on acceptance) -------------
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_neg_a;
    logic            w_neg_b;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_mul_zero;
    logic            w_spec;
    logic [XLEN-1:0] w_spec_res;

    always_comb begin
        w_is_div   = bus.op[2];
        w_a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) ||
                     (bus.op == 3'd4) || (bus.op == 3'd6);
        w_b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        w_neg_a    = w_a_signed && bus.rs1_val[XLEN-1];
        w_neg_b    = w_b_signed && bus.rs2_val[XLEN-1];
        w_abs_a    = w_neg_a ? ('0 - bus.rs1_val) : bus.rs1_val;
        w_abs_b    = w_neg_b ? ('0 - bus.rs2_val) : bus.rs2_val;
        w_div_zero = w_is_div && (bus.rs2_val == '0);
        w_ovf      = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                     (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) &&
                     (bus.rs2_val == '1);
        w_mul_zero = !w_is_div && ((bus.rs1_val == '0) || (bus.rs2_val == '0));
        w_spec     = w_div_zero || w_ovf || w_mul_zero;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        w_spec_res = '0;
        if (w_div_zero)
            w_spec_res = bus.op[1] ? bus.rs1_val : '1;
        else if (w_ovf)
            w_spec_res = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end

    // ---------------- one iteration of the datapath ------------------------
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_trial;
    logic [2*XLEN-1:0] w_acc_next;

    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
        // Partial remainder shifted left with the next dividend bit, minus divisor;
        // bit XLEN set means the subtraction borrowed (restore).
        w_trial = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]} - {1'b0, r_b};
        if (!r_op[2])
            w_acc_next = {w_sum, r_acc[XLEN-1:1]};
        else if (!w_trial[XLEN])
            w_acc_next = {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        else
            w_acc_next = {r_acc[2*XLEN-2:0], 1'b0};
    end

    // ---------------- sign correction of the final iteration ---------------
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    always_comb begin
        w_prod = r_neg_res ? ('0 - w_acc_next) : w_acc_next;
        w_quo  = r_neg_res ? ('0 - w_acc_next[XLEN-1:0]) : w_acc_next[XLEN-1:0];
        w_rem  = r_neg_rem ? ('0 - w_acc_next[2*XLEN-1:XLEN])
                           : w_acc_next[2*XLEN-1:XLEN];
        if (r_spec)
            w_result = r_spec_res;
        else if (r_op[2])
            w_result = r_op[1] ? w_rem : w_quo;
        else if (r_op == 3'd0)
            w_result = w_prod[XLEN-1:0];
        else
            w_result = w_prod[2*XLEN-1:XLEN];
    end

    // ---------------- control ----------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= '0;
            r_rd       <= '0;
            r_cnt      <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_spec     <= 1'b0;
            r_spec_res <= '0;
            r_a3       <= '0;
            r_wd3      <= '0;
            r_we       <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op       <= bus.op;
                        r_rd       <= bus.rd_addr;
                        r_cnt      <= 5'd31;
                        r_b        <= w_abs_b;
                        r_acc      <= {{XLEN{1'b0}}, w_abs_a};
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_spec     <= w_spec;
                        r_spec_res <= w_spec_res;
                        if (EARLY_OUT && w_spec) begin
                            r_state <= S_WB;
                            r_a3    <= bus.rd_addr;
                            r_wd3   <= w_spec_res;
                            r_we    <= (bus.rd_addr != 5'd0);
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt - 5'd1;
                    if (r_cnt == 5'd0) begin
                        r_state <= S_WB;
                        r_a3    <= r_rd;
                        r_wd3   <= w_result;
                        r_we    <= (r_rd != 5'd0);
                    end
                end
                S_WB:    r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.a3   = r_a3;
    assign bus.wd3  = r_wd3;
    assign bus.we   = r_we;
endmodule
